// File: rtl/icache_assoc.sv
// Set-associative instruction cache with round-robin victim selection and beat-wise line fill.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_assoc #(
    parameter int CACHE_SIZE        = 16,
    parameter int LINE_SIZE         = 4,
    parameter int NUM_WAYS          = 2,
    parameter int MEM_ADDR_BITS     = 8,
    parameter int MEM_DATA_BITS     = 16,
    parameter int MEM_DATA_READ_NUM = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [MEM_ADDR_BITS-1:0]                   addr,
    input  logic                                       request_valid,
    output logic                                       request_ready,
    output logic [MEM_DATA_BITS-1:0]                   instruction,
    input  logic                                       flush,
    output logic                                       mem_read_valid,
    output logic [MEM_ADDR_BITS-1:0]                   mem_read_address,
    input  logic                                       mem_read_ready,
    input  logic [MEM_DATA_READ_NUM*MEM_DATA_BITS-1:0] mem_read_data
`ifdef ICACHE_PERF_EN
    ,
    output logic [15:0]                                hit_count,
    output logic [15:0]                                miss_count
`endif
);

    localparam int NUM_SETS  = CACHE_SIZE / (LINE_SIZE * NUM_WAYS);
    localparam int BEAT      = (MEM_DATA_READ_NUM < LINE_SIZE) ? MEM_DATA_READ_NUM : LINE_SIZE;
    localparam int NUM_BEATS = LINE_SIZE / BEAT;
    localparam int OFF_W     = $clog2(LINE_SIZE);
    localparam int IDX_W     = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 0;
    localparam int IDX_S     = (IDX_W > 0) ? IDX_W : 1;
    localparam int TAG_W     = MEM_ADDR_BITS - OFF_W - IDX_W;
    localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int BCNT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESPOND} state_t;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_S-1:0] req_idx;
    logic [OFF_W-1:0] req_off;

    assign req_tag = addr[MEM_ADDR_BITS-1 -: TAG_W];
    assign req_off = addr[OFF_W-1:0];

    generate
        if (IDX_W > 0) begin : g_idx
            assign req_idx = addr[OFF_W +: IDX_S];
        end else begin : g_no_idx
            assign req_idx = '0;
        end
    endgenerate

    logic [MEM_DATA_BITS-1:0] data_mem [NUM_WAYS][NUM_SETS][LINE_SIZE];
    logic [TAG_W-1:0]         tag_mem  [NUM_WAYS][NUM_SETS];

    state_t                             state_q, state_d;
    logic [BCNT_W-1:0]                  beat_q, beat_d;
    logic                               fill_done_q, fill_done_d;
    logic                               request_ready_q, request_ready_d;
    logic [MEM_DATA_BITS-1:0]           instruction_q, instruction_d;
    logic                               mem_read_valid_q, mem_read_valid_d;
    logic [MEM_ADDR_BITS-1:0]           mem_read_address_q, mem_read_address_d;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]  valid_q, valid_d;
    logic [NUM_SETS-1:0][WAY_W-1:0]     ptr_q, ptr_d;

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic             data_we;
    logic             tag_we;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[req_idx][WAY_W'(w)] && (tag_mem[WAY_W'(w)][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Descending scan so the lowest-numbered invalid way wins over the round-robin pointer.
    always_comb begin
        victim = ptr_q[req_idx];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][WAY_W'(w)]) begin
                victim = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        beat_d             = beat_q;
        fill_done_d        = fill_done_q;
        request_ready_d    = request_ready_q;
        instruction_d      = instruction_q;
        mem_read_valid_d   = mem_read_valid_q;
        mem_read_address_d = mem_read_address_q;
        valid_d            = valid_q;
        ptr_d              = ptr_q;
        data_we            = 1'b0;
        tag_we             = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    valid_d = '0;
                    ptr_d   = '0;
                end else if (request_valid) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                fill_done_d = 1'b0;
                if (hit) begin
                    instruction_d   = data_mem[hit_way][req_idx][req_off];
                    request_ready_d = 1'b1;
                    state_d         = RESPOND;
                end else begin
                    state_d            = FILL;
                    beat_d             = '0;
                    mem_read_valid_d   = 1'b1;
                    mem_read_address_d = {addr[MEM_ADDR_BITS-1:OFF_W], OFF_W'(0)};
                end
            end
            FILL: begin
                if (mem_read_valid_q) begin
                    if (mem_read_ready) begin
                        data_we          = 1'b1;
                        mem_read_valid_d = 1'b0;
                        if (beat_q == BCNT_W'(NUM_BEATS - 1)) begin
                            tag_we                   = 1'b1;
                            valid_d[req_idx][victim] = 1'b1;
                            ptr_d[req_idx]           = (ptr_q[req_idx] == WAY_W'(NUM_WAYS - 1)) ?
                                                       '0 : ptr_q[req_idx] + 1'b1;
                            fill_done_d              = 1'b1;
                            state_d                  = LOOKUP;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end else begin
                    // Re-issue after the mandatory one-cycle gap between beats.
                    mem_read_valid_d   = 1'b1;
                    mem_read_address_d = {addr[MEM_ADDR_BITS-1:OFF_W], OFF_W'(int'(beat_q) * BEAT)};
                end
            end
            RESPOND: begin
                if (!request_valid) begin
                    request_ready_d = 1'b0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            beat_q             <= '0;
            fill_done_q        <= 1'b0;
            request_ready_q    <= 1'b0;
            instruction_q      <= '0;
            mem_read_valid_q   <= 1'b0;
            mem_read_address_q <= '0;
            valid_q            <= '0;
            ptr_q              <= '0;
        end else begin
            state_q            <= state_d;
            beat_q             <= beat_d;
            fill_done_q        <= fill_done_d;
            request_ready_q    <= request_ready_d;
            instruction_q      <= instruction_d;
            mem_read_valid_q   <= mem_read_valid_d;
            mem_read_address_q <= mem_read_address_d;
            valid_q            <= valid_d;
            ptr_q              <= ptr_d;
        end
    end

    // Data and tag arrays are never reset; validity alone decides whether a line is usable.
    always_ff @(posedge clk) begin
        if (data_we) begin
            for (int i = 0; i < BEAT; i++) begin
                data_mem[victim][req_idx][OFF_W'(int'(beat_q) * BEAT + i)] <=
                    mem_read_data[i*MEM_DATA_BITS +: MEM_DATA_BITS];
            end
        end
        if (tag_we) begin
            tag_mem[victim][req_idx] <= req_tag;
        end
    end

    assign request_ready    = request_ready_q;
    assign instruction      = instruction_q;
    assign mem_read_valid   = mem_read_valid_q;
    assign mem_read_address = mem_read_address_q;

`ifdef ICACHE_PERF_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    // The LOOKUP that follows a fill is a guaranteed hit and is not counted.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == LOOKUP && !fill_done_q) begin
            if (hit && hit_count_q != 16'hFFFF) begin
                hit_count_d = hit_count_q + 16'd1;
            end
            if (!hit && miss_count_q != 16'hFFFF) begin
                miss_count_d = miss_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
